lsu_mmio_stall: RTL

Parametrised successor to the single-cycle load-store unit: data memory plus memory-mapped I/O behind a req/ready handshake with configurable data-memory latency, so the core can stall.
Generalises output peripherals to NUM_HEX seven-segment channels plus LEDR, LEDG, LCD and a switch input.
Sits between the core's ALU/regfile and the board I/O.
Loads are sign/zero-extended and misaligned accesses are flagged.

---
 rtl/lsu_pkg.sv | 76 +++++++
 rtl/lsu_dmem.sv | 29 ++
 rtl/lsu_mmio_stall.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, address map and lane helpers for the stalling LSU
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {REG_DMEM, REG_OUT, REG_IN, REG_RSVD} region_e;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} lsu_state_e;
    typedef enum logic [2:0] {OUT_LEDR, OUT_LEDG, OUT_HEX, OUT_LCD, OUT_NONE} out_sel_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    localparam logic [15:0] DMEM_END  = 16'h2000;
    localparam logic [15:0] ADDR_LEDR = 16'h7000;
    localparam logic [15:0] ADDR_LEDG = 16'h7010;
    localparam logic [15:0] ADDR_HEX  = 16'h7020;
    localparam logic [15:0] ADDR_LCD  = 16'h7040;
    localparam logic [15:0] ADDR_SW   = 16'h7800;

    // Unsupported encodings fall through to word size.
    function automatic size_e access_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_B;
            F3_LH, F3_LHU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] st, input size_e sz);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{st[7:0]}};
            SZ_H:    r = {2{st[15:0]}};
            default: r = st;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (access_size(f3))
            SZ_B:    r = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    r = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - single-port byte-enabled data RAM with registered read
module lsu_dmem #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Contents and read register are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lsu_mmio_stall.sv
// rtl/lsu_mmio_stall.sv - stalling load/store unit with DMEM and board MMIO; LSU_SW_SYNC_EN adds a switch synchronizer
module lsu_mmio_stall
    import lsu_pkg::*;
#(
    parameter int DMEM_AW = 11,
    parameter int NUM_HEX = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          st_data_i,
    input  logic [2:0]           funct3_i,
    output logic                 ready_o,
    output logic [31:0]          ld_data_o,
    output logic                 misaligned_o,
    input  logic [31:0]          io_sw_i,
    output logic [31:0]          io_ledr_o,
    output logic [31:0]          io_ledg_o,
    output logic [31:0]          io_lcd_o,
    output logic [7*NUM_HEX-1:0] io_hex_o
);

    lsu_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [31:0] ledr_q, ledg_q, lcd_q;
    logic [6:0]  hex_q [NUM_HEX];
    logic [31:0] sw_val;

    logic [31:0]        ld_q;
    logic               mis_q;
    logic               resp_dmem_q;
    logic [DMEM_AW-1:0] acc_addr_q;
    logic               acc_we_q;
    logic [3:0]         acc_be_q;
    logic [31:0]        acc_wdata_q;
    logic [1:0]         acc_off_q;
    logic [2:0]         acc_f3_q;

    logic               mem_en, mem_we;
    logic [3:0]         mem_be;
    logic [DMEM_AW-1:0] mem_addr;
    logic [31:0]        mem_wdata, mem_rdata;

    region_e     region;
    out_sel_e    out_sel;
    size_e       sz;
    logic [2:0]  hex_idx;
    logic        hex_ok, misal, accept, dmem_acc;
    logic [3:0]  be;
    logic [31:0] lanes, io_word, io_ld;

`ifdef LSU_SW_SYNC_EN
    logic [31:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= io_sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_val = sw_sync_q;
`else
    assign sw_val = io_sw_i;
`endif

    assign sz       = access_size(funct3_i);
    assign be       = byte_enable(sz, addr_i[1:0]);
    assign lanes    = store_lanes(st_data_i, sz);
    assign hex_idx  = addr_i[4:2];
    assign hex_ok   = int'(hex_idx) < NUM_HEX;
    assign misal    = ((sz == SZ_H) && addr_i[0]) || ((sz == SZ_W) && (addr_i[1:0] != 2'b00));
    assign accept   = (state_q == ST_IDLE) && req_i;
    assign dmem_acc = (region == REG_DMEM) && !misal;

    always_comb begin
        region  = REG_RSVD;
        out_sel = OUT_NONE;
        if (addr_i[31:16] == 16'h0) begin
            if (addr_i[15:0] < DMEM_END) begin
                region = REG_DMEM;
            end else if (addr_i[15:2] == ADDR_LEDR[15:2]) begin
                region  = REG_OUT;
                out_sel = OUT_LEDR;
            end else if (addr_i[15:2] == ADDR_LEDG[15:2]) begin
                region  = REG_OUT;
                out_sel = OUT_LEDG;
            end else if ((addr_i[15:5] == ADDR_HEX[15:5]) && hex_ok) begin
                region  = REG_OUT;
                out_sel = OUT_HEX;
            end else if (addr_i[15:2] == ADDR_LCD[15:2]) begin
                region  = REG_OUT;
                out_sel = OUT_LCD;
            end else if (addr_i[15:2] == ADDR_SW[15:2]) begin
                region = REG_IN;
            end
        end
    end

    always_comb begin
        io_word = '0;
        if (region == REG_OUT) begin
            case (out_sel)
                OUT_LEDR: io_word = ledr_q;
                OUT_LEDG: io_word = ledg_q;
                OUT_LCD:  io_word = lcd_q;
                OUT_HEX: begin
                    for (int k = 0; k < NUM_HEX; k++) begin
                        if (hex_idx == 3'(k)) io_word = {25'h0, hex_q[k]};
                    end
                end
                default: io_word = '0;
            endcase
        end else if (region == REG_IN) begin
            io_word = sw_val;
        end
    end

    // DMEM and reserved regions leave io_word at zero, so io_ld is zero for them.
    assign io_ld = (misal || we_i) ? 32'h0 : load_extend(io_word, funct3_i, addr_i[1:0]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_en    = 1'b0;
        mem_we    = acc_we_q;
        mem_be    = acc_be_q;
        mem_addr  = acc_addr_q;
        mem_wdata = acc_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (dmem_acc && (MEM_LAT > 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(MEM_LAT - 1);
                    end else begin
                        state_d = ST_RESP;
                        if (dmem_acc) begin
                            mem_en    = 1'b1;
                            mem_we    = we_i;
                            mem_be    = be;
                            mem_addr  = addr_i[DMEM_AW+1:2];
                            mem_wdata = lanes;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_en  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ld_q        <= '0;
            mis_q       <= 1'b0;
            resp_dmem_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_we_q    <= 1'b0;
            acc_be_q    <= '0;
            acc_wdata_q <= '0;
            acc_off_q   <= '0;
            acc_f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ld_q        <= io_ld;
                mis_q       <= misal;
                resp_dmem_q <= dmem_acc && !we_i;
                acc_addr_q  <= addr_i[DMEM_AW+1:2];
                acc_we_q    <= we_i;
                acc_be_q    <= be;
                acc_wdata_q <= lanes;
                acc_off_q   <= addr_i[1:0];
                acc_f3_q    <= funct3_i;
            end
        end
    end

    // I/O stores commit on the accept edge; the switch register is read-only.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
        end else if (accept && we_i && !misal && (region == REG_OUT)) begin
            case (out_sel)
                OUT_LEDR: ledr_q <= lane_merge(ledr_q, lanes, be);
                OUT_LEDG: ledg_q <= lane_merge(ledg_q, lanes, be);
                OUT_LCD:  lcd_q  <= lane_merge(lcd_q, lanes, be);
                OUT_HEX: begin
                    for (int k = 0; k < NUM_HEX; k++) begin
                        if (hex_idx == 3'(k)) hex_q[k] <= st_data_i[6:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gates the RAM enable so a write due on the reset edge is dropped.
    lsu_dmem #(.AW(DMEM_AW)) u_dmem (
        .clk   (clk_i),
        .en    (mem_en && rst_ni),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign ready_o      = (state_q == ST_RESP);
    assign misaligned_o = mis_q;
    assign ld_data_o    = resp_dmem_q ? load_extend(mem_rdata, acc_f3_q, acc_off_q) : ld_q;
    assign io_ledr_o    = ledr_q;
    assign io_ledg_o    = ledg_q;
    assign io_lcd_o     = lcd_q;

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign io_hex_o[7*k +: 7] = hex_q[k];
    end

endmodule
